// File: rtl/icache_stream_prefetch.sv
// icache_stream_prefetch
//
// Next-line instruction prefetcher that sits beside the icache in the IF
// stage. A trigger from IF starts a stream of DEPTH single-line AXI INCR
// bursts covering the lines that follow the triggering line. Each returned
// line lands in its own buffer entry. The icache refill path looks up the
// buffer on a miss and can consume a hitting line instead of going to
// memory. Only the AR and R channels are used; the parent ties off AW/W/B.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   trig_valid/addr/ready  prefetch request from IF (ready only when idle)
//   flush                  invalidate every entry and abort the stream
//   busy                   a stream or a drain is in progress
//   lk_addr/hit/data       combinational lookup of the line buffer
//   lk_consume             icache took the hitting line; the entry is freed
//   ar*, r*                read-only AXI master (rid is ignored)
module icache_stream_prefetch #(
   parameter int LINE_WORDS = 8,
   parameter int DEPTH      = 2,
   parameter int AXI_ID     = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      trig_valid,
   input  logic [31:0]               trig_addr,
   output logic                      trig_ready,
   input  logic                      flush,
   output logic                      busy,
   input  logic [31:0]               lk_addr,
   output logic                      lk_hit,
   output logic [32*LINE_WORDS-1:0]  lk_data,
   input  logic                      lk_consume,
   output logic [3:0]                arid,
   output logic [31:0]               araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [3:0]                rid,
   input  logic [31:0]               rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready
);

   localparam int OFF = $clog2(LINE_WORDS * 4);
   localparam int LAW = 32 - OFF;
   localparam int CW  = $clog2(LINE_WORDS);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, AR, RD, DRAIN} state_t;

   state_t           state, state_n;
   logic [DEPTH-1:0] valid_q, valid_c, valid_n, hit_sel;
   logic [LAW-1:0]   line_q [DEPTH];
   logic [31:0]      data_q [DEPTH][LINE_WORDS];
   logic [LAW-1:0]   base_q, base_n, cur_line;
   logic [IW-1:0]    idx_q;
   logic [CW-1:0]    cnt_q;
   logic             err_q, err_now, last_idx, trig_match;
   logic             unused_inputs;

   assign unused_inputs = ^{rid, trig_addr[OFF-1:0], lk_addr[OFF-1:0]};

   assign arid     = 4'(AXI_ID);
   assign arlen    = 8'(LINE_WORDS - 1);
   assign arsize   = 3'd2;
   assign arburst  = 2'b01;

   assign base_n   = trig_addr[31:OFF] + LAW'(1);
   assign cur_line = base_q + LAW'(idx_q);
   assign last_idx = (idx_q == IW'(DEPTH - 1));
   assign err_now  = err_q | (rresp != 2'b00);

   // Buffer lookup. Entries only become valid once their whole burst has
   // arrived, so a line that is still filling can never hit. If two entries
   // ever held the same line, the lowest index wins.
   always_comb begin
      lk_hit  = 1'b0;
      hit_sel = '0;
      lk_data = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && (line_q[i] == lk_addr[31:OFF])) begin
            lk_hit     = 1'b1;
            hit_sel    = '0;
            hit_sel[i] = 1'b1;
            for (int w = 0; w < LINE_WORDS; w++) begin
               lk_data[w*32 +: 32] = data_q[i][w];
            end
         end
      end
   end

   // A consume in the same cycle as a trigger is applied first, so the
   // duplicate-stream check sees the valid bits with the consumed entry gone.
   always_comb begin
      valid_c    = valid_q & ~(hit_sel & {DEPTH{lk_consume}});
      trig_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_c[i] && (line_q[i] == base_n)) begin
            trig_match = 1'b1;
         end
      end
   end

   // Stream FSM: next state, AXI handshake outputs and the next valid bits.
   // Flush clears the valid bits from any state. Once an AR has been accepted
   // the burst must still be drained, so a flush from then on goes through
   // DRAIN unless it coincides with the final beat.
   always_comb begin
      state_n    = state;
      valid_n    = valid_c;
      trig_ready = 1'b0;
      busy       = 1'b1;
      arvalid    = 1'b0;
      rready     = 1'b0;
      araddr     = '0;
      case (state)
         IDLE: begin
            trig_ready = 1'b1;
            busy       = 1'b0;
            if (trig_valid && !flush && !trig_match) begin
               state_n = AR;
               valid_n = '0;
            end
         end
         AR: begin
            arvalid = 1'b1;
            araddr  = {cur_line, {OFF{1'b0}}};
            if (arready) begin
               state_n = flush ? DRAIN : RD;
            end else if (flush) begin
               state_n = IDLE;
            end
         end
         RD: begin
            rready = 1'b1;
            if (rvalid && rlast) begin
               if (!err_now && !flush) begin
                  valid_n[idx_q] = 1'b1;
               end
               if (flush || err_now || last_idx) begin
                  state_n = IDLE;
               end else begin
                  state_n = AR;
               end
            end else if (flush) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            rready = 1'b1;
            if (rvalid && rlast) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (flush) begin
         valid_n = '0;
      end
   end

   // Control registers: state, valid bits, stream base, line index, beat
   // count and the sticky per-burst error flag. The beat count saturates so
   // that an overlong burst keeps rewriting the last word of the line.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         valid_q <= '0;
         base_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         valid_q <= valid_n;
         if (state == IDLE && state_n == AR) begin
            base_q <= base_n;
            idx_q  <= '0;
         end
         if (state == AR && arready) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end
         if (state == RD && rvalid) begin
            err_q <= err_now;
            if (cnt_q != CW'(LINE_WORDS - 1)) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         if (state == RD && state_n == AR) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   // Line address and data storage. These carry no reset because an entry
   // is only ever read while its valid bit is set, and that bit is reset.
   // The line address is recorded while the entry's AR is outstanding.
   always_ff @(posedge clk) begin
      if (state == AR) begin
         line_q[idx_q] <= cur_line;
      end
      if (state == RD && rvalid) begin
         data_q[idx_q][cnt_q] <= rdata;
      end
   end

endmodule

// File: tb/tb_icache_stream_prefetch.sv
// Self-checking bench for icache_stream_prefetch (LINE_WORDS=8, DEPTH=2).
// A behavioural AXI read slave answers every AR with a burst of
// mem_word(addr) values. It logs each accepted AR into obs_ar. The scenario
// tasks push the AR addresses they expect into exp_ar and compare the two
// queues once the stream has ended.
module tb_icache_stream_prefetch;

   localparam int LW = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
   } ar_t;

   logic          clk;
   logic          resetn;
   logic          trig_valid;
   logic [31:0]   trig_addr;
   logic          trig_ready;
   logic          flush;
   logic          busy;
   logic [31:0]   lk_addr;
   logic          lk_hit;
   logic [32*LW-1:0] lk_data;
   logic          lk_consume;
   logic [3:0]    arid;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [3:0]    rid;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   int            checks = 0;
   int            errors = 0;

   logic [31:0]   exp_ar [$];
   ar_t           obs_ar [$];

   int            ar_delay = 0;
   bit            err_armed = 0;
   int            err_beat = 0;
   bit            slave_abort = 0;

   icache_stream_prefetch #(
      .LINE_WORDS(LW),
      .DEPTH(2),
      .AXI_ID(1)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .trig_valid(trig_valid),
      .trig_addr(trig_addr),
      .trig_ready(trig_ready),
      .flush(flush),
      .busy(busy),
      .lk_addr(lk_addr),
      .lk_hit(lk_hit),
      .lk_data(lk_data),
      .lk_consume(lk_consume),
      .arid(arid),
      .araddr(araddr),
      .arlen(arlen),
      .arsize(arsize),
      .arburst(arburst),
      .arvalid(arvalid),
      .arready(arready),
      .rid(rid),
      .rdata(rdata),
      .rresp(rresp),
      .rlast(rlast),
      .rvalid(rvalid),
      .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
   endfunction

   // Behavioural AXI slave. It acts on the falling edge: it first books the
   // handshakes that happened on the preceding rising edge, then drives the
   // values the DUT will sample on the next one.
   initial begin : slave
      int          beat;
      int          ar_wait;
      bit          ar_fire;
      bit          r_fire;
      ar_t         ar_cap;
      logic [31:0] burst_q [$];
      beat = 0; ar_wait = 0; ar_fire = 0; r_fire = 0; ar_cap = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      rlast = 1'b0; rid = 4'd0;
      forever begin
         @(negedge clk);
         if (slave_abort) begin
            burst_q.delete();
            beat = 0; ar_fire = 0; r_fire = 0; slave_abort = 0;
         end
         if (ar_fire) begin
            obs_ar.push_back(ar_cap);
            burst_q.push_back(ar_cap.addr);
         end
         if (r_fire) begin
            if (rresp != 2'b00) err_armed = 0;
            if (rlast) begin
               void'(burst_q.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (arvalid === 1'b1) begin
            if (ar_wait > 0) begin
               arready = 1'b0;
               ar_wait--;
            end else begin
               arready = 1'b1;
            end
         end else begin
            arready = 1'b0;
            ar_wait = ar_delay;
         end
         if (burst_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(burst_q[0] + 32'(beat * 4));
            rlast  = (beat == LW - 1);
            rresp  = (err_armed && beat == err_beat) ? 2'b10 : 2'b00;
         end else begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
         end
         ar_fire = (arvalid === 1'b1) && arready;
         ar_cap  = '{araddr, arlen, arsize, arburst, arid};
         r_fire  = rvalid && (rready === 1'b1);
      end
   end

   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] a);
      lk_addr = a;
      #1;
   endtask

   task automatic trigger(input logic [31:0] a);
      trig_addr  = a;
      trig_valid = 1'b1;
      tick();
      trig_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b0) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; trig_valid = 1'b0; trig_addr = '0; flush = 1'b0;
      lk_addr = '0; lk_consume = 1'b0;
      repeat (3) tick();
      checks++;
      if ({trig_ready, busy, arvalid, rready} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got ready/busy/arvalid/rready=%b required 1000",
                  {trig_ready, busy, arvalid, rready});
      end
      checks++;
      if (araddr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_araddr: got %h required 00000000", araddr);
      end
      checks++;
      if (lk_hit !== 1'b0 || lk_data !== '0) begin
         errors++;
         $display("[TB] FAIL reset_lookup: got hit=%b word0=%h required hit=0 data=0", lk_hit, lk_data[31:0]);
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (trig_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got ready=%b busy=%b required 1 0", trig_ready, busy);
      end
   endtask

   task automatic test_stream();
      bit ok; ar_t o; logic [31:0] e;
      exp_ar.push_back(32'h1000_0020);
      exp_ar.push_back(32'h1000_0040);
      trigger(32'h1000_0004);
      checks++;
      if (busy !== 1'b1 || trig_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stream_start: got busy=%b ready=%b required 1 0", busy, trig_ready);
      end
      wait_idle(100, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL stream_done: got busy=%b required 0 within 100 cycles", busy); end
      checks++;
      if (obs_ar.size() != 2) begin errors++; $display("[TB] FAIL stream_ar_count: got %0d required 2", obs_ar.size()); end
      while (exp_ar.size() > 0) begin
         e = exp_ar.pop_front();
         checks++;
         if (obs_ar.size() == 0) begin
            errors++; $display("[TB] FAIL stream_ar: got none required addr %h", e);
         end else begin
            o = obs_ar.pop_front();
            if (o.addr !== e || o.len !== 8'd7 || o.size !== 3'd2 || o.burst !== 2'b01 || o.id !== 4'd1) begin
               errors++;
               $display("[TB] FAIL stream_ar: got addr=%h len=%0d size=%0d burst=%b id=%0d required addr=%h len=7 size=2 burst=01 id=1",
                        o.addr, o.len, o.size, o.burst, o.id, e);
            end
         end
      end
      obs_ar.delete();
      look(32'h1000_0030);
      checks++;
      if (lk_hit !== 1'b1 || lk_data[31:0] !== mem_word(32'h1000_0020)) begin
         errors++;
         $display("[TB] FAIL stream_hit0: got hit=%b word0=%h required 1 %h", lk_hit, lk_data[31:0], mem_word(32'h1000_0020));
      end
      checks++;
      if (lk_data[255:224] !== mem_word(32'h1000_003C)) begin
         errors++;
         $display("[TB] FAIL stream_word7: got %h required %h", lk_data[255:224], mem_word(32'h1000_003C));
      end
      look(32'h1000_005C);
      checks++;
      if (lk_hit !== 1'b1 || lk_data[31:0] !== mem_word(32'h1000_0040)) begin
         errors++;
         $display("[TB] FAIL stream_hit1: got hit=%b word0=%h required 1 %h", lk_hit, lk_data[31:0], mem_word(32'h1000_0040));
      end
      look(32'h1000_0060);
      checks++;
      if (lk_hit !== 1'b0 || lk_data !== '0) begin
         errors++;
         $display("[TB] FAIL stream_miss: got hit=%b word0=%h required 0 0", lk_hit, lk_data[31:0]);
      end
   endtask

   task automatic test_consume();
      bit ok; ar_t o; logic [31:0] e;
      look(32'h1000_0030);
      lk_consume = 1'b1;
      tick();
      lk_consume = 1'b0;
      look(32'h1000_0030);
      checks++;
      if (lk_hit !== 1'b0) begin errors++; $display("[TB] FAIL consume_gone: got hit=%b required 0", lk_hit); end
      look(32'h1000_0040);
      checks++;
      if (lk_hit !== 1'b1) begin errors++; $display("[TB] FAIL consume_other: got hit=%b required 1", lk_hit); end
      trigger(32'h1000_0024);
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || obs_ar.size() != 0) begin
         errors++;
         $display("[TB] FAIL retrig_ignored: got busy=%b ars=%0d required 0 0", busy, obs_ar.size());
      end
      look(32'h1000_0040);
      checks++;
      if (lk_hit !== 1'b1) begin errors++; $display("[TB] FAIL retrig_keep: got hit=%b required 1", lk_hit); end
      for (int pass = 0; pass < 2; pass++) begin
         exp_ar.push_back(32'h1000_0020);
         exp_ar.push_back(32'h1000_0040);
         if (pass == 0) begin
            trigger(32'h1000_0004);
         end else begin
            look(32'h1000_0020);
            lk_consume = 1'b1;
            trigger(32'h1000_0004);
            lk_consume = 1'b0;
         end
         checks++;
         if (busy !== 1'b1) begin errors++; $display("[TB] FAIL retrig_start%0d: got busy=%b required 1", pass, busy); end
         wait_idle(100, ok);
         checks++;
         if (!ok || obs_ar.size() != 2) begin
            errors++;
            $display("[TB] FAIL retrig_done%0d: got idle=%0d ars=%0d required 1 2", pass, ok, obs_ar.size());
         end
         while (exp_ar.size() > 0) begin
            e = exp_ar.pop_front();
            checks++;
            if (obs_ar.size() == 0) begin
               errors++; $display("[TB] FAIL retrig_ar%0d: got none required %h", pass, e);
            end else begin
               o = obs_ar.pop_front();
               if (o.addr !== e) begin errors++; $display("[TB] FAIL retrig_ar%0d: got %h required %h", pass, o.addr, e); end
            end
         end
         obs_ar.delete();
         look(32'h1000_0020);
         checks++;
         if (lk_hit !== 1'b1 || lk_data[31:0] !== mem_word(32'h1000_0020)) begin
            errors++;
            $display("[TB] FAIL retrig_hit%0d: got hit=%b word0=%h required 1 %h", pass, lk_hit, lk_data[31:0], mem_word(32'h1000_0020));
         end
      end
   endtask

   task automatic test_flush();
      bit ok; bit bad_rready; bit saw_hit; int drain_cycles; ar_t o;
      exp_ar.push_back(32'h2000_0020);
      look(32'h2000_0020);
      trigger(32'h2000_0000);
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b1 || rready !== 1'b1) begin
         errors++; $display("[TB] FAIL flush_drain: got busy=%b rready=%b required 1 1", busy, rready);
      end
      ok = 0; bad_rready = 0; saw_hit = 0; drain_cycles = 0;
      for (int i = 0; i < 50; i++) begin
         if (busy === 1'b0) begin ok = 1; break; end
         if (rready !== 1'b1) bad_rready = 1;
         if (lk_hit !== 1'b0) saw_hit = 1;
         drain_cycles++;
         tick();
      end
      checks++;
      if (!ok || drain_cycles != 5 || bad_rready) begin
         errors++;
         $display("[TB] FAIL flush_len: got idle=%0d cycles=%0d rready_drop=%0d required 1 5 0", ok, drain_cycles, bad_rready);
      end
      checks++;
      if (saw_hit || lk_hit !== 1'b0 || trig_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_state: got hit_seen=%0d hit=%b ready=%b required 0 0 1", saw_hit, lk_hit, trig_ready);
      end
      checks++;
      if (obs_ar.size() != 1) begin
         errors++; $display("[TB] FAIL flush_ar_count: got %0d required 1", obs_ar.size());
      end else begin
         o = obs_ar.pop_front();
         if (o.addr !== exp_ar[0]) begin errors++; $display("[TB] FAIL flush_ar: got %h required %h", o.addr, exp_ar[0]); end
      end
      exp_ar.delete();
      obs_ar.delete();
   endtask

   task automatic test_error();
      bit ok; ar_t o;
      exp_ar.push_back(32'h3000_0020);
      err_beat = 4;
      err_armed = 1;
      trigger(32'h3000_0000);
      wait_idle(100, ok);
      checks++;
      if (!ok || obs_ar.size() != 1) begin
         errors++; $display("[TB] FAIL error_ar_count: got idle=%0d ars=%0d required 1 1", ok, obs_ar.size());
      end else begin
         o = obs_ar.pop_front();
         if (o.addr !== exp_ar[0]) begin errors++; $display("[TB] FAIL error_ar: got %h required %h", o.addr, exp_ar[0]); end
      end
      exp_ar.delete();
      obs_ar.delete();
      look(32'h3000_0020);
      checks++;
      if (lk_hit !== 1'b0 || trig_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL error_entry: got hit=%b ready=%b required 0 1", lk_hit, trig_ready);
      end
      err_armed = 0;
   endtask

   task automatic test_flush_trigger();
      flush = 1'b1;
      trigger(32'h5000_0000);
      flush = 1'b0;
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || obs_ar.size() != 0) begin
         errors++; $display("[TB] FAIL flush_trig: got busy=%b ars=%0d required 0 0", busy, obs_ar.size());
      end
      obs_ar.delete();
   endtask

   task automatic test_ar_stall_reset();
      bit stable; bit ok; ar_t o; logic [31:0] e;
      exp_ar.push_back(32'h4000_0020);
      exp_ar.push_back(32'h4000_0040);
      ar_delay = 10;
      trigger(32'h4000_0000);
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         if (arvalid !== 1'b1 || araddr !== 32'h4000_0020) stable = 0;
         tick();
      end
      ar_delay = 0;
      checks++;
      if (!stable || obs_ar.size() != 0) begin
         errors++; $display("[TB] FAIL stall_hold: got stable=%0d ars=%0d required 1 0", stable, obs_ar.size());
      end
      look(32'h4000_0020);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (lk_hit === 1'b1) begin ok = 1; break; end
         tick();
      end
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL stall_fill: got hit=%b required 1 within 60 cycles", lk_hit); end
      repeat (3) tick();
      checks++;
      if (rready !== 1'b1) begin errors++; $display("[TB] FAIL stall_in_r: got rready=%b required 1", rready); end
      resetn = 1'b0;
      slave_abort = 1;
      tick();
      checks++;
      if ({arvalid, rready, busy, lk_hit, trig_ready} !== 5'b00001 || araddr !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midr_reset: got arvalid/rready/busy/hit/ready=%b araddr=%h required 00001 00000000",
                  {arvalid, rready, busy, lk_hit, trig_ready}, araddr);
      end
      resetn = 1'b1;
      tick();
      while (exp_ar.size() > 0) begin
         e = exp_ar.pop_front();
         checks++;
         if (obs_ar.size() == 0) begin
            errors++; $display("[TB] FAIL stall_ar: got none required %h", e);
         end else begin
            o = obs_ar.pop_front();
            if (o.addr !== e) begin errors++; $display("[TB] FAIL stall_ar: got %h required %h", o.addr, e); end
         end
      end
      obs_ar.delete();
   endtask

   task automatic test_wrap();
      bit ok; ar_t o; logic [31:0] e;
      exp_ar.push_back(32'h0000_0000);
      exp_ar.push_back(32'h0000_0020);
      trigger(32'hFFFF_FFE0);
      wait_idle(100, ok);
      checks++;
      if (!ok || obs_ar.size() != 2) begin
         errors++; $display("[TB] FAIL wrap_done: got idle=%0d ars=%0d required 1 2", ok, obs_ar.size());
      end
      while (exp_ar.size() > 0) begin
         e = exp_ar.pop_front();
         checks++;
         if (obs_ar.size() == 0) begin
            errors++; $display("[TB] FAIL wrap_ar: got none required %h", e);
         end else begin
            o = obs_ar.pop_front();
            if (o.addr !== e) begin errors++; $display("[TB] FAIL wrap_ar: got %h required %h", o.addr, e); end
         end
      end
      obs_ar.delete();
      look(32'h0000_0004);
      checks++;
      if (lk_hit !== 1'b1 || lk_data[31:0] !== mem_word(32'h0)) begin
         errors++;
         $display("[TB] FAIL wrap_hit: got hit=%b word0=%h required 1 %h", lk_hit, lk_data[31:0], mem_word(32'h0));
      end
   endtask

   initial begin : main
      test_reset();
      test_stream();
      test_consume();
      test_flush();
      test_error();
      test_flush_trigger();
      test_ar_stall_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
